approx_mul_rr_scheduler: RTL and testbench

- Shares one unsigned W×W multiplier datapath among NREQ requesters. The datapath is external and holds an approximate product path plus an exact product path, muxed by a select line.
- Each request carries an exact/approximate mode bit.
- The block arbitrates round-robin, registers operands into the datapath, and tracks the result latency with a tag pipeline.
- Results are buffered in a response FIFO with per-requester ID. Credit-based issue prevents FIFO overflow.

---
 rtl/approx_mul_rr_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_approx_mul_rr_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mul_rr_scheduler.sv
// Round-robin scheduler sharing one external W x W multiplier datapath
// (approximate and exact paths) among NREQ requesters. Accepted operands are
// registered into the datapath, a tag pipeline follows the datapath latency,
// and finished products are queued in a response FIFO tagged with the
// requester index. Issue is credit-limited so the FIFO can never overflow.
module approx_mul_rr_scheduler #(
   parameter int NREQ    = 4,
   parameter int W       = 8,
   parameter int MUL_LAT = 0,
   parameter int DEPTH   = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*W-1:0]       req_x,
   input  logic [NREQ*W-1:0]       req_y,
   input  logic [NREQ-1:0]         req_exact,
   output logic [W-1:0]            mul_x,
   output logic [W-1:0]            mul_y,
   output logic                    mul_sel_exact,
   input  logic [2*W-1:0]          mul_z,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [2*W-1:0]          rsp_z,
   output logic                    rsp_exact,
   output logic                    busy
);

   localparam int IDW = $clog2(NREQ);
   localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW  = $clog2(DEPTH + 1);
   localparam int NST = MUL_LAT + 1;
   localparam int EW  = IDW + 1 + 2 * W;

   // round-robin pointer and credit (ops in tag pipeline + FIFO entries)
   logic [IDW-1:0]            ptr_q, ptr_d;
   logic [CW-1:0]             cred_q, cred_d;

   // operand registers feeding the datapath
   logic [W-1:0]              mx_q, mx_d;
   logic [W-1:0]              my_q, my_d;
   logic                      msel_q, msel_d;

   // tag pipeline, one stage per datapath register plus the operand stage
   logic [NST-1:0]            tv_q, tv_d;
   logic [NST-1:0][IDW-1:0]   tid_q, tid_d;
   logic [NST-1:0]            tex_q, tex_d;

   // response FIFO
   logic [AW-1:0]             wp_q, wp_d;
   logic [AW-1:0]             rp_q, rp_d;
   logic [CW-1:0]             occ_q, occ_d;
   logic [EW-1:0]             mem_q [DEPTH];
   logic [EW-1:0]             push_word_d;
   logic [EW-1:0]             head;

   logic                      issue_ok;
   logic                      accept;
   logic                      push;
   logic                      pop;
   logic [NREQ-1:0]           grant;
   logic [IDW-1:0]            gidx;
   logic [IDW-1:0]            cand;
   logic [IDW:0]              cand_sum;
   logic                      arb_hit;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Credit is judged from registered state only; a same-cycle pop does not help.
   assign issue_ok = rst_n && (cred_q < CW'(DEPTH));
   assign pop      = rsp_valid & rsp_ready;
   assign push     = tv_q[NST-1];

   // Round-robin search starting just after the last granted requester.
   always_comb begin
      grant    = '0;
      gidx     = '0;
      cand     = '0;
      cand_sum = '0;
      arb_hit  = 1'b0;
      for (int off = 1; off <= NREQ; off++) begin
         cand_sum = {1'b0, ptr_q} + (IDW+1)'(off);
         if (cand_sum >= (IDW+1)'(NREQ)) begin
            cand_sum = cand_sum - (IDW+1)'(NREQ);
         end
         cand = cand_sum[IDW-1:0];
         if (!arb_hit && req_valid[cand]) begin
            grant[cand] = 1'b1;
            gidx        = cand;
            arb_hit     = 1'b1;
         end
      end
      if (!issue_ok) begin
         grant = '0;
      end
   end

   assign req_ready = grant;
   assign accept    = |grant;

   // Load operands and pointer on accept; otherwise hold to avoid datapath toggling.
   always_comb begin
      ptr_d  = ptr_q;
      mx_d   = mx_q;
      my_d   = my_q;
      msel_d = msel_q;
      if (accept) begin
         ptr_d  = gidx;
         mx_d   = W'(req_x >> (gidx * W));
         my_d   = W'(req_y >> (gidx * W));
         msel_d = req_exact[gidx];
      end
   end

   // Advance the tag pipeline every cycle; bubbles enter when nothing is accepted.
   always_comb begin
      tv_d     = tv_q;
      tid_d    = tid_q;
      tex_d    = tex_q;
      tv_d[0]  = accept;
      tid_d[0] = accept ? gidx : '0;
      tex_d[0] = accept ? req_exact[gidx] : 1'b0;
      for (int s = 1; s < NST; s++) begin
         tv_d[s]  = tv_q[s-1];
         tid_d[s] = tid_q[s-1];
         tex_d[s] = tex_q[s-1];
      end
   end

   // FIFO pointer, occupancy and credit bookkeeping.
   always_comb begin
      push_word_d = {tid_q[NST-1], tex_q[NST-1], mul_z};
      wp_d        = push ? ptr_inc(wp_q) : wp_q;
      rp_d        = pop ? ptr_inc(rp_q) : rp_q;
      case ({push, pop})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase
      case ({accept, pop})
         2'b10:   cred_d = cred_q + 1'b1;
         2'b01:   cred_d = cred_q - 1'b1;
         default: cred_d = cred_q;
      endcase
   end

   // State register; reset discards in-flight tags and FIFO contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q  <= IDW'(NREQ - 1);
         cred_q <= '0;
         mx_q   <= '0;
         my_q   <= '0;
         msel_q <= 1'b0;
         tv_q   <= '0;
         tid_q  <= '0;
         tex_q  <= '0;
         wp_q   <= '0;
         rp_q   <= '0;
         occ_q  <= '0;
      end else begin
         ptr_q  <= ptr_d;
         cred_q <= cred_d;
         mx_q   <= mx_d;
         my_q   <= my_d;
         msel_q <= msel_d;
         tv_q   <= tv_d;
         tid_q  <= tid_d;
         tex_q  <= tex_d;
         wp_q   <= wp_d;
         rp_q   <= rp_d;
         occ_q  <= occ_d;
      end
   end

   // FIFO storage holds data only; validity comes from the occupancy count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wp_q] <= push_word_d;
      end
   end

   assign head          = mem_q[rp_q];
   assign rsp_valid     = (occ_q != '0);
   assign rsp_id        = rsp_valid ? head[EW-1 -: IDW] : '0;
   assign rsp_exact     = rsp_valid ? head[2*W] : 1'b0;
   assign rsp_z         = rsp_valid ? head[2*W-1:0] : '0;
   assign busy          = (cred_q != '0);
   assign mul_x         = mx_q;
   assign mul_y         = my_q;
   assign mul_sel_exact = msel_q;

endmodule

// File: tb/tb_approx_mul_rr_scheduler.sv
// Bench for approx_mul_rr_scheduler: two instances (datapath latency 0 and 2)
// share stimulus; each is compared cycle by cycle against an issue-log model.
module tb_approx_mul_rr_scheduler;

   localparam int NREQ  = 4;
   localparam int W     = 8;
   localparam int DEPTH = 4;
   localparam int IDW   = 2;
   localparam int ZW    = 2 * W;
   localparam int LOGN  = 4096;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_exact;
   logic [NREQ*W-1:0]     req_x;
   logic [NREQ*W-1:0]     req_y;
   logic                  rsp_ready;

   logic [NREQ-1:0]       rdy0, rdy2;
   logic [W-1:0]          mx0, mx2, my0, my2;
   logic                  msel0, msel2;
   logic [ZW-1:0]         mz0, mz2;
   logic                  rv0, rv2;
   logic [IDW-1:0]        rid0, rid2;
   logic [ZW-1:0]         rz0, rz2;
   logic                  rex0, rex2;
   logic                  bsy0, bsy2;

   logic [NREQ-1:0]       rdy_a [2];
   logic [W-1:0]          mx_a [2];
   logic [W-1:0]          my_a [2];
   logic                  msel_a [2];
   logic                  rv_a [2];
   logic [IDW-1:0]        rid_a [2];
   logic [ZW-1:0]         rz_a [2];
   logic                  rex_a [2];
   logic                  bsy_a [2];

   logic [ZW-1:0]         p1, p2;

   typedef struct {
      int            id;
      logic [ZW-1:0] z;
      logic          ex;
      int            push;
   } op_t;

   op_t             lg [2][LOGN];
   int              n_iss [2];
   int              n_pop [2];
   int              ptr_m [2];
   logic [W-1:0]    lx [2];
   logic [W-1:0]    ly [2];
   logic            le [2];
   int              eg [2];
   logic            pop_e [2];
   int              acc_cnt [2];
   int              cyc;
   int              n_chk;
   int              n_fail;

   always #5 clk = ~clk;

   // Datapath model: exact product, or product of operands with 2 LSBs dropped.
   function automatic logic [ZW-1:0] dp_f(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ex);
      logic [ZW-1:0] xa, ya;
      xa = ZW'({x[W-1:2], 2'b00});
      ya = ZW'({y[W-1:2], 2'b00});
      return ex ? ZW'(x) * ZW'(y) : xa * ya;
   endfunction

   function automatic int lat(input int g);
      return (g == 0) ? 0 : 2;
   endfunction

   assign mz0 = dp_f(mx0, my0, msel0);
   always @(posedge clk) begin
      p1 <= dp_f(mx2, my2, msel2);
      p2 <= p1;
   end
   assign mz2 = p2;

   always_comb begin
      rdy_a[0] = rdy0;  rdy_a[1] = rdy2;
      mx_a[0] = mx0;    mx_a[1] = mx2;
      my_a[0] = my0;    my_a[1] = my2;
      msel_a[0] = msel0; msel_a[1] = msel2;
      rv_a[0] = rv0;    rv_a[1] = rv2;
      rid_a[0] = rid0;  rid_a[1] = rid2;
      rz_a[0] = rz0;    rz_a[1] = rz2;
      rex_a[0] = rex0;  rex_a[1] = rex2;
      bsy_a[0] = bsy0;  bsy_a[1] = bsy2;
   end

   approx_mul_rr_scheduler #(.NREQ(NREQ), .W(W), .MUL_LAT(0), .DEPTH(DEPTH)) u_lat0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy0),
      .req_x(req_x), .req_y(req_y), .req_exact(req_exact),
      .mul_x(mx0), .mul_y(my0), .mul_sel_exact(msel0), .mul_z(mz0),
      .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_id(rid0), .rsp_z(rz0),
      .rsp_exact(rex0), .busy(bsy0)
   );

   approx_mul_rr_scheduler #(.NREQ(NREQ), .W(W), .MUL_LAT(2), .DEPTH(DEPTH)) u_lat2 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy2),
      .req_x(req_x), .req_y(req_y), .req_exact(req_exact),
      .mul_x(mx2), .mul_y(my2), .mul_sel_exact(msel2), .mul_z(mz2),
      .rsp_valid(rv2), .rsp_ready(rsp_ready), .rsp_id(rid2), .rsp_z(rz2),
      .rsp_exact(rex2), .busy(bsy2)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int g = 0; g < 2; g++) begin
         n_pop[g] = n_iss[g];
         ptr_m[g] = NREQ - 1;
         lx[g]    = '0;
         ly[g]    = '0;
         le[g]    = 1'b0;
      end
   endtask

   // One clock: check both DUTs against the model, then advance the model.
   task automatic tick();
      int              cr;
      logic            erv;
      logic [NREQ-1:0] erdy;
      #1;
      if (!rst_n) model_reset();
      for (int g = 0; g < 2; g++) begin
         cr    = n_iss[g] - n_pop[g];
         eg[g] = -1;
         if (rst_n && cr < DEPTH) begin
            for (int o = 1; o <= NREQ; o++) begin
               int c;
               c = (ptr_m[g] + o) % NREQ;
               if (eg[g] < 0 && ((req_valid >> c) & 1) != 0) eg[g] = c;
            end
         end
         erdy = '0;
         if (eg[g] >= 0) erdy = NREQ'(1) << eg[g];
         erv = (cr > 0) && (lg[g][n_pop[g]].push <= cyc);
         check_val($sformatf("req_ready[u%0d]", g), 32'(rdy_a[g]), 32'(erdy));
         check_val($sformatf("rsp_valid[u%0d]", g), 32'(rv_a[g]), 32'(erv));
         check_val($sformatf("busy[u%0d]", g), 32'(bsy_a[g]), 32'(cr > 0));
         check_val($sformatf("mul_x[u%0d]", g), 32'(mx_a[g]), 32'(lx[g]));
         check_val($sformatf("mul_y[u%0d]", g), 32'(my_a[g]), 32'(ly[g]));
         check_val($sformatf("mul_sel[u%0d]", g), 32'(msel_a[g]), 32'(le[g]));
         if (erv) begin
            check_val($sformatf("rsp_id[u%0d]", g), 32'(rid_a[g]), 32'(lg[g][n_pop[g]].id));
            check_val($sformatf("rsp_z[u%0d]", g), 32'(rz_a[g]), 32'(lg[g][n_pop[g]].z));
            check_val($sformatf("rsp_exact[u%0d]", g), 32'(rex_a[g]), 32'(lg[g][n_pop[g]].ex));
         end
         pop_e[g] = erv && rsp_ready;
         if ((rdy_a[g] & req_valid) != '0) acc_cnt[g]++;
      end
      @(posedge clk);
      cyc++;
      if (rst_n) begin
         for (int g = 0; g < 2; g++) begin
            if (pop_e[g]) n_pop[g]++;
            if (eg[g] >= 0) begin
               int c;
               c = eg[g];
               lx[g] = W'(req_x >> (c * W));
               ly[g] = W'(req_y >> (c * W));
               le[g] = ((req_exact >> c) & 1) != 0;
               lg[g][n_iss[g]].id   = c;
               lg[g][n_iss[g]].z    = dp_f(lx[g], ly[g], le[g]);
               lg[g][n_iss[g]].ex   = le[g];
               lg[g][n_iss[g]].push = cyc + 1 + lat(g);
               n_iss[g]++;
               ptr_m[g] = c;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic rand_ops();
      req_x     = {$urandom, $urandom};
      req_y     = {$urandom, $urandom};
      req_exact = NREQ'($urandom);
   endtask

   task automatic idle(input int n);
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (n) tick();
   endtask

   initial begin
      n_chk = 0; n_fail = 0; cyc = 0;
      for (int g = 0; g < 2; g++) begin
         n_iss[g] = 0; n_pop[g] = 0; acc_cnt[g] = 0;
      end
      rst_n = 1'b0; req_valid = '0; req_x = '0; req_y = '0; req_exact = '0;
      rsp_ready = 1'b1;
      model_reset();
      @(negedge clk);
      req_valid = '1;
      tick();
      tick();
      for (int g = 0; g < 2; g++) begin
         check_val($sformatf("reset_id[u%0d]", g), 32'(rid_a[g]), 0);
         check_val($sformatf("reset_z[u%0d]", g), 32'(rz_a[g]), 0);
         check_val($sformatf("reset_exact[u%0d]", g), 32'(rex_a[g]), 0);
      end
      req_valid = '0;
      rst_n = 1'b1;

      // single request from requester 0
      req_x = '0; req_y = '0; req_exact = 4'b0001;
      req_x[7:0] = 8'd200; req_y[7:0] = 8'd150;
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      tick();
      check_val("t1_rv_lat0", 32'(rv0), 1);
      check_val("t1_id_lat0", 32'(rid0), 0);
      check_val("t1_z_lat0", 32'(rz0), 30000);
      check_val("t1_ex_lat0", 32'(rex0), 1);
      tick();
      check_val("t1_rv_lat2_early", 32'(rv2), 0);
      tick();
      check_val("t1_rv_lat2", 32'(rv2), 1);
      check_val("t1_z_lat2", 32'(rz2), 30000);
      idle(4);

      // all requesters continuously valid, consumer draining
      req_valid = '1;
      for (int k = 0; k < 16; k++) begin
         rand_ops();
         #1;
         check_val("rr_order_lat0", 32'(rdy0), 32'(NREQ'(1) << ((k + 1) % NREQ)));
         tick();
      end
      idle(8);

      // backpressure: credit limits issue to DEPTH
      rsp_ready = 1'b0;
      req_valid = '1;
      acc_cnt[0] = 0; acc_cnt[1] = 0;
      for (int k = 0; k < 8; k++) begin
         rand_ops();
         tick();
      end
      check_val("bp_accepts_lat0", 32'(acc_cnt[0]), DEPTH);
      check_val("bp_accepts_lat2", 32'(acc_cnt[1]), DEPTH);
      check_val("bp_busy_lat0", 32'(bsy0), 1);
      check_val("bp_busy_lat2", 32'(bsy2), 1);
      check_val("bp_ready_lat0", 32'(rdy0), 0);
      check_val("bp_ready_lat2", 32'(rdy2), 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      acc_cnt[0] = 0; acc_cnt[1] = 0;
      repeat (4) tick();
      check_val("bp_one_more_lat0", 32'(acc_cnt[0]), 1);
      check_val("bp_one_more_lat2", 32'(acc_cnt[1]), 1);
      idle(10);

      // reset with three ops in flight and one queued (latency-2 instance)
      rsp_ready = 1'b0;
      req_valid = '1;
      for (int k = 0; k < 4; k++) begin
         rand_ops();
         tick();
      end
      req_valid = '0;
      rst_n = 1'b0;
      tick();
      check_val("rst_mid_rv_lat2", 32'(rv2), 0);
      check_val("rst_mid_z_lat2", 32'(rz2), 0);
      check_val("rst_mid_busy_lat0", 32'(bsy0), 0);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      req_valid = '1;
      rand_ops();
      #1;
      check_val("rst_first_grant_lat0", 32'(rdy0), 1);
      check_val("rst_first_grant_lat2", 32'(rdy2), 1);
      tick();
      idle(6);

      // wrap-around search after grants to 0 and 3; operands hold while idle
      req_valid = 4'b0001; rand_ops(); tick();
      req_valid = 4'b1000; rand_ops(); tick();
      req_valid = '0;
      repeat (3) begin
         rand_ops();
         tick();
      end
      check_val("hold_mul_x_lat0", 32'(mx0), 32'(lx[0]));
      req_valid = 4'b0100;
      rand_ops();
      #1;
      check_val("wrap_grant_lat0", 32'(rdy0), 32'b0100);
      tick();
      idle(6);

      // randomized traffic with occasional reset pulses
      for (int k = 0; k < 600; k++) begin
         req_valid = NREQ'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         rand_ops();
         if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
         tick();
         rst_n = 1'b1;
      end
      idle(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
